// File: rtl/ofifo_drain_if.sv
// ofifo_drain_if: job control, OFIFO pop side and psum SRAM write port of the drain engine.
interface ofifo_drain_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 4
);
  logic                     start;
  logic [addr_w-1:0]        base_addr;
  logic [addr_w:0]          len;
  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_output;
  logic                     ofifo_rd;
  logic                     sram_cen;
  logic                     sram_wen;
  logic [addr_w-1:0]        sram_addr;
  logic [col*psum_bw-1:0]   sram_din;
  logic                     busy;
  logic                     done;
  modport slave (
    input  start, base_addr, len, ofifo_valid, ofifo_output,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_din, busy, done
  );
  modport master (
    output start, base_addr, len, ofifo_valid, ofifo_output,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_din, busy, done
  );
endinterface

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops len OFIFO rows and writes them to consecutive psum SRAM rows one cycle later.
// Define DRAIN_RELU_EN to clamp each signed lane at zero on its way into the SRAM.
module ofifo_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 4
) (
  input  logic           clk,
  input  logic           reset,
  ofifo_drain_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state, state_nx;
  logic [addr_w-1:0]      base;
  logic [addr_w:0]        len_q, issued;
  logic                   pending;
  logic [col*psum_bw-1:0] din_nx;
  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] lane;
    assign lane = bus.ofifo_output[i*psum_bw +: psum_bw];
`ifdef DRAIN_RELU_EN
    assign din_nx[i*psum_bw +: psum_bw] = lane[psum_bw-1] ? '0 : lane;
`else
    assign din_nx[i*psum_bw +: psum_bw] = lane;
`endif
  end
  always_comb begin
    state_nx     = state;
    state_nx     = state == IDLE ? (bus.start ? RUN : IDLE)
                 : state == RUN  ? (issued == len_q ? DONE : RUN)
                 : IDLE;
    bus.ofifo_rd = state == RUN && bus.ofifo_valid && issued < len_q;
    bus.sram_cen = ~pending;
    bus.sram_wen = ~pending;
    bus.busy     = state == RUN;
    bus.done     = state == DONE;
  end
  // sram_addr/sram_din only move on a pop, so they hold while no write is pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      base          <= '0;
      len_q         <= '0;
      issued        <= '0;
      pending       <= 1'b0;
      bus.sram_addr <= '0;
      bus.sram_din  <= '0;
    end else begin
      state   <= state_nx;
      pending <= bus.ofifo_rd;
      if (state == IDLE && bus.start) begin
        base   <= bus.base_addr;
        len_q  <= bus.len;
        issued <= '0;
      end else if (bus.ofifo_rd) begin
        issued        <= issued + 1'b1;
        bus.sram_addr <= base + issued[addr_w-1:0];
        bus.sram_din  <= din_nx;
      end
    end
  end
endmodule

// File: doc/ofifo_drain.md
OFIFO_DRAIN -- requirements
Module: ofifo_drain

Interface
REQ-001 SHALL have parameter col, default 8, number of psum lanes.
REQ-002 SHALL have parameter psum_bw, default 16, width of one signed psum lane.
REQ-003 SHALL have parameter addr_w, default 4, psum SRAM address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a drain job.
REQ-007 SHALL have port base_addr  input  addr_w  first SRAM row to write, latched on start.
REQ-008 SHALL have port len  input  addr_w+1  number of rows to drain (0..2^addr_w), latched on start.
REQ-009 SHALL have port ofifo_valid  input  1  OFIFO holds at least one full row.
REQ-010 SHALL have port ofifo_output  input  col*psum_bw  OFIFO head row, lane i at bits [(i+1)*psum_bw-1 : i*psum_bw].
REQ-011 SHALL have port ofifo_rd  output  1  OFIFO pop; head row is sampled on the same rising edge.
REQ-012 SHALL have port sram_cen  output  1  psum SRAM chip enable, active-low.
REQ-013 SHALL have port sram_wen  output  1  psum SRAM write enable, active-low.
REQ-014 SHALL have port sram_addr  output  addr_w  psum SRAM row address.
REQ-015 SHALL have port sram_din  output  col*psum_bw  psum SRAM write data.
REQ-016 SHALL have port busy  output  1  high while in RUN.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL go IDLE->RUN on start=1 in IDLE, latching base_addr, len, issued=0, pending=0.
REQ-020 SHALL ignore start in RUN and DONE; latched job parameters stay unchanged.
REQ-021 SHALL drive ofifo_rd = (state==RUN) && ofifo_valid && (issued<len), combinational from registered state only.
REQ-022 SHALL, on each edge with ofifo_rd=1, register ofifo_output into sram_din, register sram_addr = base+issued modulo 2^addr_w, set pending=1, and increment issued.
REQ-023 SHALL, on an edge with ofifo_rd=0, clear pending.
REQ-024 SHALL drive sram_cen=sram_wen=~pending, so each write occurs exactly one cycle after its pop.
REQ-025 SHALL hold sram_addr and sram_din stable when pending=0.
REQ-026 SHALL stall in RUN, with no pop and no write, while ofifo_valid=0; draining resumes when valid returns.
REQ-027 SHALL go RUN->DONE on the edge that ends a cycle with issued==len; that cycle carries the final pending write, if any.
REQ-028 SHALL, for len=0, enter RUN and move to DONE after exactly one cycle with no pop and no write.
REQ-029 SHALL wrap addresses modulo 2^addr_w; base=14, len=4 writes rows 14, 15, 0, 1.
REQ-030 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-031 SHALL drive busy=1 only in RUN.
REQ-032 SHALL complete a job of len N with continuous valid in N+2 cycles from start to done.

Reset
REQ-033 SHALL, on reset assertion (asynchronous, including mid-job), force state=IDLE, issued=0, pending=0, ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_din=0, busy=0, done=0.
REQ-034 SHALL not issue any SRAM write or pop after a mid-job reset until a new start is received.

Configuration
REQ-035 SHALL, when macro DRAIN_RELU_EN is defined, register each lane into sram_din as max(lane,0), treating the lane as signed psum_bw.
REQ-036 SHALL, when DRAIN_RELU_EN is undefined, register sram_din bit-exact from ofifo_output.

Verification
REQ-037 SHALL cover: base=0, len=3, valid constant, rows A,B,C -> writes A@0, B@1, C@2 in consecutive cycles; done on cycle 5 after start.
REQ-038 SHALL cover: len=2, valid low for 3 cycles after first pop -> no write and no pop during the gap; second write follows the valid return by one cycle.
REQ-039 SHALL cover: base=14, len=4 -> sram_addr sequence 14, 15, 0, 1.
REQ-040 SHALL cover: len=0 -> no ofifo_rd, sram_cen stays 1, done pulses 2 cycles after start.
REQ-041 SHALL cover: reset mid-job after 1 of 4 writes -> outputs at reset values immediately; no further writes follow.
REQ-042 SHALL cover: lane value 0xFFF6 (-10) -> written as 0x0000 with DRAIN_RELU_EN defined, 0xFFF6 without; start pulsed during RUN -> ignored.
